acondicionamiento_param: RTL
============================

Name: acondicionamiento_param

Overview:
Parametrised successor to the fixed controller-to-PWM conditioning stage. It takes each signed control sample from the I-PD controller, applies a programmable fixed-point gain and signed offset, and clamps the result into the unsigned duty range of the PWM generator. It also applies an optional per-sample slew-rate limit and reports saturation. It sits between the I_PD controller and the PWM/servo driver, replacing the hard-wired ×1 + constant-offset + bit-slice path.

Parameters:
N, 18, width of signed control sample and offset
GAIN_W, 8, width of unsigned gain word
FRAC, 4, fractional bits of gain (gain = gain_word / 2^FRAC)
OUT_W, 10, duty width; valid duty range 0 .. 2^OUT_W-1
RESET_DUTY, 512, duty value after reset (mid-scale)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  one-cycle strobe: u and configuration inputs are valid
u  in  N  signed control sample (two's complement)
gain  in  GAIN_W  unsigned gain word, Q(GAIN_W-FRAC).FRAC
offset  in  N  signed offset added after scaling
slew_max  in  OUT_W  max duty change per output update; 0 disables limiter
duty  out  OUT_W  conditioned duty word to PWM
duty_msb8  out  8  duty[OUT_W-1 -: 8], coarse duty for 8-bit PWM
out_valid  out  1  one-cycle pulse when duty is updated
sat_hi  out  1  last update clamped at 2^OUT_W-1
sat_lo  out  1  last update clamped at 0
slew_active  out  1  last update was slew-limited

Behaviour:
- Reset (reset=0, asynchronous): all pipeline registers and valid bits are 0; duty=RESET_DUTY; out_valid, sat_hi, sat_lo and slew_active are 0. In-flight samples are discarded.
- Pipeline has 3 stages, advanced only by valid tokens. in_valid at edge t produces out_valid=1 for exactly one cycle after edge t+3. Back-to-back in_valid on every cycle is supported at full throughput, with each sample processed independently.
- S1, capture: u, gain, offset and slew_max are registered together on in_valid. Configuration changes mid-stream therefore affect only samples strobed after the change.
- S2, scale:
  - p = u × {1'b0,gain}, signed, N+GAIN_W+1 bits, no overflow.
  - q = p >>> FRAC (arithmetic; rounds toward −inf).
  - s = q + sign-extended offset, computed with 1 guard bit and registered.
- S3, clamp:
  - t = 0 if s<0 (sat_lo=1); t = 2^OUT_W-1 if s>2^OUT_W-1 (sat_hi=1); else t=s[OUT_W-1:0]. sat_hi and sat_lo are mutually exclusive.
  - Slew limit, relative to the current registered duty:
    - If slew_max≠0 and t>duty+slew_max: duty ← duty+slew_max.
    - If slew_max≠0 and t<duty−slew_max: duty ← duty−slew_max.
    - Otherwise duty ← t.
    - slew_active=1 exactly when limiting occurred. Comparisons are unsigned and carried in OUT_W+1 bits, so no wrap-around occurs.
- Flags update only with out_valid and hold between updates. duty holds its value when no token is present.
- duty_msb8 is combinational from the duty register.

Test Plan:
- Reset: hold reset=0 mid-stream with 3 tokens in flight → duty=512; no out_valid during reset or after release; all flags 0.
- Nominal: gain=16, offset=512, slew_max=0, u=100, in_valid at t → out_valid at t+3; duty=612, duty_msb8=153, flags 0.
- Saturation: u=600 → duty=1023, sat_hi=1. Then u=-600 → duty=0, sat_lo=1, sat_hi=0.
- Rounding: gain=8 (0.5), offset=512, u=-3 → duty=510. Same setup with u=3 → duty=513.
- Slew: duty=512, slew_max=50, u=600 strobed 12 times → duty 562, 612 … 1012, then 1023. slew_active=1 on the first 10 updates and 0 on the 11th. sat_hi=1 throughout.
- Throughput/config coherency: in_valid on 4 consecutive cycles, with gain changed 16→32 on the 3rd → 4 consecutive out_valid pulses; the first two outputs use gain 16 and the last two use gain 32.

Source files
------------

// File: rtl/acondicionamiento_param.sv
// Controller-to-PWM conditioning: gain, offset, clamp and slew limit.
// Three valid-token stages feed a registered duty output.
module acondicionamiento_param #(
  parameter int N          = 18,
  parameter int GAIN_W     = 8,
  parameter int FRAC       = 4,
  parameter int OUT_W      = 10,
  parameter int RESET_DUTY = 512
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [N-1:0]        u,
  input  logic [GAIN_W-1:0]   gain,
  input  logic [N-1:0]        offset,
  input  logic [OUT_W-1:0]    slew_max,
  output logic [OUT_W-1:0]    duty,
  output logic [7:0]          duty_msb8,
  output logic                out_valid,
  output logic                sat_hi,
  output logic                sat_lo,
  output logic                slew_active
);

  localparam int PW = N + GAIN_W + 1;
  localparam int SW = PW + 1;
  localparam logic [OUT_W-1:0] DMAX = '1;
  localparam logic [OUT_W-1:0] DRST = OUT_W'(RESET_DUTY);

  // S1: capture
  logic              v1_q;
  logic [N-1:0]      u1_q;
  logic [GAIN_W-1:0] g1_q;
  logic [N-1:0]      o1_q;
  logic [OUT_W-1:0]  sl1_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1_q  <= 1'b0;
      u1_q  <= '0;
      g1_q  <= '0;
      o1_q  <= '0;
      sl1_q <= '0;
    end else begin
      v1_q <= in_valid;
      if (in_valid) begin
        u1_q  <= u;
        g1_q  <= gain;
        o1_q  <= offset;
        sl1_q <= slew_max;
      end
    end
  end

  // S2: scale and offset
  logic signed [PW-1:0] ue;
  logic signed [PW-1:0] ge;
  logic signed [PW-1:0] p;
  logic signed [PW-1:0] q;
  logic signed [SW-1:0] s_d;

  assign ue  = PW'($signed(u1_q));
  assign ge  = PW'($signed({1'b0, g1_q}));
  assign p   = ue * ge;
  assign q   = p >>> FRAC;
  assign s_d = SW'(q) + SW'($signed(o1_q));

  logic                 v2_q;
  logic signed [SW-1:0] s2_q;
  logic [OUT_W-1:0]     sl2_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v2_q  <= 1'b0;
      s2_q  <= '0;
      sl2_q <= '0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) begin
        s2_q  <= s_d;
        sl2_q <= sl1_q;
      end
    end
  end

  // S3: clamp into duty range
  logic             neg;
  logic             over;
  logic [OUT_W-1:0] t_d;

  assign neg  = s2_q[SW-1];
  assign over = !neg && (|s2_q[SW-2:OUT_W]);

  always_comb begin
    t_d = s2_q[OUT_W-1:0];
    if (neg)       t_d = '0;
    else if (over) t_d = DMAX;
  end

  logic             v3_q;
  logic [OUT_W-1:0] t3_q;
  logic             hi3_q;
  logic             lo3_q;
  logic [OUT_W-1:0] sl3_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v3_q  <= 1'b0;
      t3_q  <= '0;
      hi3_q <= 1'b0;
      lo3_q <= 1'b0;
      sl3_q <= '0;
    end else begin
      v3_q <= v2_q;
      if (v2_q) begin
        t3_q  <= t_d;
        hi3_q <= over;
        lo3_q <= neg;
        sl3_q <= sl2_q;
      end
    end
  end

  // Output: slew limit against the live duty register
  logic [OUT_W-1:0] duty_q, duty_d;
  logic             ov_q;
  logic             hi_q, hi_d;
  logic             lo_q, lo_d;
  logic             sa_q, sa_d;
  logic [OUT_W:0]   up;
  logic [OUT_W:0]   tup;
  logic             lim_en;

  assign up     = {1'b0, duty_q} + {1'b0, sl3_q};
  assign tup    = {1'b0, t3_q} + {1'b0, sl3_q};
  assign lim_en = |sl3_q;

  always_comb begin
    duty_d = duty_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    sa_d   = sa_q;
    if (v3_q) begin
      hi_d = hi3_q;
      lo_d = lo3_q;
      sa_d = 1'b0;
      duty_d = t3_q;
      if (lim_en && ({1'b0, t3_q} > up)) begin
        duty_d = up[OUT_W-1:0];
        sa_d   = 1'b1;
      end else if (lim_en && (tup < {1'b0, duty_q})) begin
        duty_d = duty_q - sl3_q;
        sa_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      duty_q <= DRST;
      ov_q   <= 1'b0;
      hi_q   <= 1'b0;
      lo_q   <= 1'b0;
      sa_q   <= 1'b0;
    end else begin
      duty_q <= duty_d;
      ov_q   <= v3_q;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      sa_q   <= sa_d;
    end
  end

  assign duty        = duty_q;
  assign duty_msb8   = duty_q[OUT_W-1 -: 8];
  assign out_valid   = ov_q;
  assign sat_hi      = hi_q;
  assign sat_lo      = lo_q;
  assign slew_active = sa_q;

endmodule
